// File: rtl/spi_regs_pkg.sv
// spi_regs_pkg
//   Shared constants for the write-only SPI register target:
//   register addresses, frame geometry, bit-counter limits and the
//   receive FSM state type.
package spi_regs_pkg;

   // Register map (7-bit address field of the frame)
   localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
   localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

   // Frame: bit 15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = data
   localparam int FRAME_BITS = 16;

   // Bit counter saturates one past a full frame so that any over-length
   // frame remains distinguishable from a correct one.
   localparam int                CNT_W    = 5;
   localparam logic [CNT_W-1:0]  CNT_FULL = 5'd16;
   localparam logic [CNT_W-1:0]  CNT_SAT  = 5'd17;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } spi_state_e;

endpackage

// File: rtl/sync_ff.sv
// sync_ff
//   Single-bit multi-flop synchronizer for an asynchronous input.
//   Ports:
//     clk  in  system clock
//     rst  in  synchronous active-high reset (chain loads RST_VAL)
//     d    in  asynchronous input
//     q    out synchronized output (STAGES clk edges of latency)
module sync_ff #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {STAGES{RST_VAL}};
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral
//   Write-only SPI mode-0 target that loads five 8-bit control registers
//   for the PWM block. Frames are 16 bits MSB first: R/W, 7-bit address,
//   8-bit data. Only complete 16-bit write frames to an address no higher
//   than MAX_ADDR change a register; everything else is discarded.
//   Ports:
//     clk, rst          system clock, synchronous active-high reset
//     sclk, copi, ncs   asynchronous SPI pins
//     en_reg_out_7_0    register 0x00
//     en_reg_out_15_8   register 0x01
//     en_reg_pwm_7_0    register 0x02
//     en_reg_pwm_15_8   register 0x03
//     pwm_duty_cycle    register 0x04
//   The receive FSM state is visible on the internal signal 'state'
//   (type spi_state_e) for monitoring.
module spi_peripheral
   import spi_regs_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   logic sclk_s, copi_s, ncs_s;
   logic sclk_d, copi_d, ncs_d;

   // nCS idles high, so its synchronizer and history reset to 1 to avoid
   // a spurious falling edge right after reset.
   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk (clk), .rst (rst), .d (sclk), .q (sclk_s)
   );
   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
      .clk (clk), .rst (rst), .d (copi), .q (copi_s)
   );
   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
      .clk (clk), .rst (rst), .d (ncs), .q (ncs_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_d <= 1'b0;
         copi_d <= 1'b0;
         ncs_d  <= 1'b1;
      end else begin
         sclk_d <= sclk_s;
         copi_d <= copi_s;
         ncs_d  <= ncs_s;
      end
   end

   logic sclk_rise, ncs_fall, ncs_rise;
   assign sclk_rise = sclk_s & ~sclk_d;
   assign ncs_fall  = ~ncs_s & ncs_d;
   assign ncs_rise  = ncs_s & ~ncs_d;

   spi_state_e            state;
   logic [CNT_W-1:0]      bit_cnt;
   logic [FRAME_BITS-1:0] shreg;
   logic                  frame_ok;

   assign frame_ok = (bit_cnt == CNT_FULL) && shreg[FRAME_BITS-1] &&
                     (shreg[14:8] <= MAX_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         bit_cnt         <= '0;
         shreg           <= '0;
         en_reg_out_7_0  <= 8'h00;
         en_reg_out_15_8 <= 8'h00;
         en_reg_pwm_7_0  <= 8'h00;
         en_reg_pwm_15_8 <= 8'h00;
         pwm_duty_cycle  <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               shreg   <= '0;
               if (ncs_fall) state <= SHIFT;
            end
            SHIFT: begin
               // An nCS rise takes priority; a coincident SCLK edge is dropped.
               // COPI is taken from its history flop, one stage later than
               // SCLK, so data settling just before the pin edge is captured.
               if (ncs_rise) begin
                  state <= COMMIT;
               end else if (sclk_rise) begin
                  shreg <= {shreg[FRAME_BITS-2:0], copi_d};
                  if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
               end
            end
            COMMIT: begin
               if (frame_ok) begin
                  case (shreg[14:8])
                     ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= shreg[7:0];
                     ADDR_EN_OUT_15_8: en_reg_out_15_8 <= shreg[7:0];
                     ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= shreg[7:0];
                     ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= shreg[7:0];
                     ADDR_PWM_DUTY:    pwm_duty_cycle  <= shreg[7:0];
                     default: ;
                  endcase
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral
//   Self-checking bench for spi_peripheral. A register-level model
//   (five bytes plus a queue of timed pending writes) predicts the outputs
//   on every clk cycle; directed frames pin the model with literal values.
module tb_spi_peripheral;

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk, copi, ncs;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8, pwm_duty_cycle;

   spi_peripheral dut (
      .clk             (clk),
      .rst             (rst),
      .sclk            (sclk),
      .copi            (copi),
      .ncs             (ncs),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle)
   );

   // ---------------- clock / reset bookkeeping ----------------
   always #5 clk = ~clk;

   int unsigned cyc = 0;     // posedges seen so far
   logic        rst_q = 1'b1;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   // ---------------- scoreboard ----------------
   int n_cmp  = 0;
   int n_fail = 0;
   logic [7:0]  model_regs [0:4];
   // pending write: {apply_cycle[31:0], addr[7:0], data[7:0]}
   logic [47:0] exp_q [$];
   bit          done = 1'b0;

   wire [39:0] dut_bus = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                          en_reg_out_15_8, en_reg_out_7_0};

   task automatic check(input string name, input logic [39:0] act,
                        input logic [39:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare: the model applies a write exactly when its cycle
   // is reached, so early or late register updates are both caught.
   initial begin
      for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
      forever begin
         @(negedge clk);
         if (!done) begin
            if (rst_q) begin
               for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
               exp_q.delete();
            end else begin
               while (exp_q.size() > 0 && exp_q[0][47:16] <= cyc) begin
                  logic [47:0] e;
                  e = exp_q.pop_front();
                  model_regs[int'(e[15:8])] = e[7:0];
               end
            end
            check("regs_cycle", dut_bus,
                  {model_regs[4], model_regs[3], model_regs[2],
                   model_regs[1], model_regs[0]});
         end
      end
   end

   // ---------------- driver tasks ----------------
   int off = 1;   // sub-cycle offset (ns) of pin changes after negedge

   task automatic step(input int n);
      if (n > 0) begin
         repeat (n) @(negedge clk);
         #(off);
      end
   endtask

   // One mode-0 bit: COPI changes at a random point of the low phase but
   // always at least one clk before SCLK rises.
   task automatic drive_bit(input logic b);
      int l, j, h;
      l = $urandom_range(3, 5);
      j = $urandom_range(0, l - 1);
      step(j);
      copi = b;
      step(l - j);
      sclk = 1'b1;
      h = $urandom_range(3, 5);
      step(h);
      sclk = 1'b0;
   endtask

   // Sends nbits of 'bits' MSB first. With 'tail', an extra SCLK rise is
   // launched together with the nCS rise; it must be ignored.
   task automatic send_frame(input logic [31:0] bits, input int nbits,
                             input bit tail);
      logic [15:0] f;
      ncs = 1'b0;
      for (int i = nbits - 1; i >= 0; i--) drive_bit(bits[i]);
      step($urandom_range(3, 5));
      if (tail) sclk = 1'b1;
      ncs = 1'b1;
      f = bits[15:0];
      if (nbits == 16 && f[15] && f[14:8] <= 7'h04)
         exp_q.push_back({cyc + 32'd4, 1'b0, f[14:8], f[7:0]});
      if (tail) begin
         step(3);
         sclk = 1'b0;
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #(3_000_000);
      n_fail++;
      $display("FAIL watchdog: time limit reached before end of stimulus");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] bits;
      int          kind, nb;
      logic [6:0]  a;
      logic [7:0]  d;
      sclk = 1'b0; copi = 1'b0; ncs = 1'b1; rst = 1'b1;
      step(4);
      rst = 1'b0;
      step(2);
      check("reset_regs", dut_bus, 40'h0);

      // Write 0x04 = 0x80; update lands exactly 4 edges after nCS rises.
      off = 2;
      send_frame(32'h8480, 16, 1'b0);
      step(3);
      check("t1_before_latency", {32'h0, pwm_duty_cycle}, 40'h0);
      step(1);
      check("t1_pwm_duty", {32'h0, pwm_duty_cycle}, 40'h80);
      check("t1_others", {8'h0, dut_bus[31:0]}, 40'h0);

      // Back-to-back writes with minimum nCS high time.
      off = 3;
      send_frame(32'h80F0, 16, 1'b0);
      step(4);
      send_frame(32'h820F, 16, 1'b0);
      step(6);
      check("t2_regs", dut_bus, 40'h80_00_0F_00_F0);

      // Read, out-of-range address, address 0x7F: nothing changes.
      send_frame(32'h0155, 16, 1'b0);
      step(4);
      send_frame(32'h8555, 16, 1'b0);
      step(4);
      send_frame(32'hFF55, 16, 1'b0);
      step(6);
      check("t3_unchanged", dut_bus, 40'h80_00_0F_00_F0);

      // 15-bit and 17-bit frames to 0x03 are dropped, the 16-bit one lands.
      off = 1;
      send_frame(32'h83AA >> 1, 15, 1'b0);
      step(5);
      send_frame({15'h0, 16'h83AA, 1'b1}, 17, 1'b0);
      step(6);
      check("t4_len_discard", {32'h0, en_reg_pwm_15_8}, 40'h0);
      send_frame(32'h83AA, 16, 1'b0);
      step(6);
      check("t4_valid", {32'h0, en_reg_pwm_15_8}, 40'hAA);

      // Reset after 10 bits of a write to 0x01 with nCS held low.
      bits = 32'h8155;
      ncs = 1'b0;
      for (int i = 15; i >= 6; i--) drive_bit(bits[i]);
      step(2);
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      step(3);
      for (int i = 5; i >= 0; i--) drive_bit(bits[i]);
      step(4);
      ncs = 1'b1;
      step(8);
      check("t5_after_reset", dut_bus, 40'h0);
      send_frame(32'h8155, 16, 1'b0);
      step(6);
      check("t5_next_frame", {32'h0, en_reg_out_15_8}, 40'h55);

      // SCLK rise coincident with nCS rise is dropped; frame stays 16 bits.
      send_frame(32'h8422, 16, 1'b1);
      step(6);
      check("t6_ncs_wins", {32'h0, pwm_duty_cycle}, 40'h22);

      // Randomized frames checked by the per-cycle scoreboard.
      for (int n = 0; n < 200; n++) begin
         off  = $urandom_range(1, 4);
         kind = $urandom_range(0, 9);
         a    = 7'($urandom_range(0, 4));
         d    = 8'($urandom_range(0, 255));
         nb   = 16;
         if (kind <= 5)      bits = {16'h0, 1'b1, a, d};
         else if (kind == 6) bits = {16'h0, 1'b0, a, d};
         else if (kind == 7) bits = {16'h0, 1'b1, 7'($urandom_range(5, 127)), d};
         else if (kind == 8) begin
            nb   = $urandom_range(1, 15);
            bits = $urandom;
         end else begin
            nb   = $urandom_range(17, 20);
            bits = $urandom;
         end
         send_frame(bits, nb, (kind <= 5) && ($urandom_range(0, 7) == 0));
         step($urandom_range(4, 8));
      end

      step(10);
      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
